// File: rtl/washer_countdown.sv
// Washer front-panel countdown sequencer: 0-99 remaining-time counter with
// prescaled decrement, load/start/pause/resume, BCD digit outputs and blink.
`timescale 1ns/1ps
module washer_countdown #(
  parameter int TICK_DIV  = 100,
  parameter int BLINK_DIV = 50,
  parameter int MAX_VAL   = 99
) (
  input  logic       qclock,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] code1,
  output logic [3:0] code2,
  output logic       busy,
  output logic       done,
  output logic       blank
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [7:0]    MAX8     = 8'(MAX_VAL);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t        state, state_n;
  logic [6:0]    cnt, cnt_n;
  logic [PW-1:0] pre, pre_n;
  logic [BW-1:0] blk;
  logic          done_n;
  logic          blink_on;

  function automatic logic [6:0] sat_load(input logic [7:0] v);
    logic [7:0] r;
    r = (v > MAX8) ? MAX8 : v;
    return r[6:0];
  endfunction

  function automatic logic [3:0] bcd_tens(input logic [6:0] c);
    logic [6:0] q;
    q = c / 7'd10;
    return q[3:0];
  endfunction

  function automatic logic [3:0] bcd_units(input logic [6:0] c);
    logic [6:0] r;
    r = c % 7'd10;
    return r[3:0];
  endfunction

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pre_n   = pre;
    done_n  = 1'b0;
    if (load) begin
      cnt_n   = sat_load(load_val);
      pre_n   = '0;
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (cnt != 7'd0) begin
              state_n = RUN;
              pre_n   = '0;
            end else begin
              state_n = DONE;
              done_n  = 1'b1;
            end
          end
        end
        RUN: begin
          // pause beats a coincident tick so the held pre/cnt lose nothing
          if (pause) begin
            state_n = PAUSE;
          end else if (pre == PRE_LAST) begin
            pre_n = '0;
            cnt_n = cnt - 7'd1;
            if (cnt == 7'd1) begin
              state_n = DONE;
              done_n  = 1'b1;
            end
          end else begin
            pre_n = pre + 1'b1;
          end
        end
        PAUSE: begin
          if (start && !pause) state_n = RUN;
        end
        DONE: begin
          state_n = DONE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // blink only counts while staying in PAUSE/DONE; any exit clears it on that edge
  assign blink_on = (state_n == state) && ((state == PAUSE) || (state == DONE));
  assign busy     = (state == RUN) || (state == PAUSE);

  always_ff @(posedge qclock) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      pre   <= '0;
      blk   <= '0;
      blank <= 1'b0;
      done  <= 1'b0;
      code1 <= '0;
      code2 <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      pre   <= pre_n;
      done  <= done_n;
      code1 <= bcd_tens(cnt);
      code2 <= bcd_units(cnt);
      if (blink_on) begin
        if (blk == BLK_LAST) begin
          blk   <= '0;
          blank <= ~blank;
        end else begin
          blk <= blk + 1'b1;
        end
      end else begin
        blk   <= '0;
        blank <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_washer_countdown.sv
// Bench for washer_countdown with TICK_DIV=4, BLINK_DIV=2: scenario tasks push
// expected digit/done events to a queue and compare them with observed events.
`timescale 1ns/1ps
module tb_washer_countdown;

  logic       qclock = 1'b0;
  logic       rst = 1'b1, load = 1'b0, start = 1'b0, pause = 1'b0;
  logic [7:0] load_val = 8'd0;
  logic [3:0] code1, code2;
  logic       busy, done, blank;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {int cyc; int kind; int val;} ev_t;  // kind 0: digits, 1: done pulse
  ev_t exp_q[$];
  ev_t obs_q[$];

  washer_countdown #(.TICK_DIV(4), .BLINK_DIV(2), .MAX_VAL(99)) dut (
    .qclock(qclock), .rst(rst), .load(load), .load_val(load_val),
    .start(start), .pause(pause), .code1(code1), .code2(code2),
    .busy(busy), .done(done), .blank(blank)
  );

  always #5 qclock = ~qclock;

  task automatic tick();
    @(posedge qclock);
    #1;
  endtask

  function automatic int digits();
    return int'(code1) * 10 + int'(code2);
  endfunction

  // records digit changes and done pulses, c = edges after the reference edge
  task automatic run_cycles(input int n);
    int last;
    last = digits();
    for (int c = 1; c <= n; c++) begin
      tick();
      if (digits() != last) begin
        obs_q.push_back('{c, 0, digits()});
        last = digits();
      end
      if (done === 1'b1) obs_q.push_back('{c, 1, 0});
    end
  endtask

  task automatic do_load(input logic [7:0] v);
    load_val = v; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_tests++; if (digits() !== 0) begin n_fail++; $display("FAIL reset_digits: got %0d expected 0", digits()); end
    n_tests++; if ({busy, done, blank} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {busy, done, blank}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_countdown();
    ev_t e, o;
    do_load(8'd13); tick();
    n_tests++; if (digits() !== 13) begin n_fail++; $display("FAIL cd_load: got %0d expected 13", digits()); end
    start = 1'b1; tick(); start = 1'b0;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL cd_busy: got %b expected 1", busy); end
    exp_q.delete(); obs_q.delete();
    for (int k = 1; k <= 13; k++) begin
      if (k == 13) exp_q.push_back('{52, 1, 0});
      exp_q.push_back('{4 * k + 1, 0, 13 - k});
    end
    run_cycles(60);
    n_tests++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL cd_events: got %0d events expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o.cyc != e.cyc || o.kind != e.kind || o.val != e.val) begin
        n_fail++; $display("FAIL cd_ev: got cyc %0d kind %0d val %0d expected cyc %0d kind %0d val %0d", o.cyc, o.kind, o.val, e.cyc, e.kind, e.val);
      end
    end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cd_busy_done: got %b expected 0", busy); end
  endtask

  task automatic test_pause_resume();
    ev_t e, o;
    logic exp_b;
    do_load(8'd26); tick();
    start = 1'b1; tick(); start = 1'b0;
    exp_q.delete(); obs_q.delete();
    exp_q.push_back('{5, 0, 25});
    exp_q.push_back('{9, 0, 24});
    run_cycles(9);
    pause = 1'b1; tick(); pause = 1'b0;
    n_tests++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL pr_pre_events: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o.cyc != e.cyc || o.val != e.val) begin
        n_fail++; $display("FAIL pr_pre_ev: got cyc %0d val %0d expected cyc %0d val %0d", o.cyc, o.val, e.cyc, e.val);
      end
    end
    n_tests++; if (digits() !== 24 || busy !== 1'b1) begin n_fail++; $display("FAIL pr_paused: got %0d busy %b expected 24 busy 1", digits(), busy); end
    for (int j = 1; j <= 20; j++) begin
      tick();
      exp_b = ((j >> 1) & 1) != 0;
      n_tests++; if (blank !== exp_b || digits() !== 24) begin n_fail++; $display("FAIL pr_blank: got blank %b digits %0d expected blank %b digits 24 (j=%0d)", blank, digits(), exp_b, j); end
    end
    start = 1'b1; tick(); start = 1'b0;
    n_tests++; if (blank !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL pr_resume: got blank %b busy %b expected 0 1", blank, busy); end
    exp_q.delete(); obs_q.delete();
    for (int k = 1; k <= 24; k++) begin
      if (k == 24) exp_q.push_back('{95, 1, 0});
      exp_q.push_back('{4 * k, 0, 24 - k});
    end
    run_cycles(100);
    n_tests++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL pr_events: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o.cyc != e.cyc || o.kind != e.kind || o.val != e.val) begin
        n_fail++; $display("FAIL pr_ev: got cyc %0d kind %0d val %0d expected cyc %0d kind %0d val %0d", o.cyc, o.kind, o.val, e.cyc, e.kind, e.val);
      end
    end
  endtask

  task automatic test_saturate_zero();
    do_load(8'd200); tick();
    n_tests++; if (code1 !== 4'd9 || code2 !== 4'd9) begin n_fail++; $display("FAIL sat_digits: got %0d/%0d expected 9/9", code1, code2); end
    do_load(8'd0); tick();
    n_tests++; if (digits() !== 0) begin n_fail++; $display("FAIL zero_digits: got %0d expected 0", digits()); end
    start = 1'b1; tick(); start = 1'b0;
    n_tests++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL zero_done: got done %b busy %b expected 1 0", done, busy); end
    tick();
    n_tests++; if (done !== 1'b0 || busy !== 1'b0 || blank !== 1'b0) begin n_fail++; $display("FAIL zero_after: got done %b busy %b blank %b expected 0 0 0", done, busy, blank); end
    tick();
    n_tests++; if (blank !== 1'b1) begin n_fail++; $display("FAIL done_blink: got %b expected 1", blank); end
    start = 1'b1; pause = 1'b1; tick(); start = 1'b0; pause = 1'b0;
    n_tests++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL done_ignore: got done %b busy %b expected 0 0", done, busy); end
  endtask

  task automatic test_load_priority();
    do_load(8'd30);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    load_val = 8'd52; load = 1'b1; start = 1'b1;
    tick();
    load = 1'b0; start = 1'b0;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL lp_busy: got %b expected 0", busy); end
    tick();
    n_tests++; if (code1 !== 4'd5 || code2 !== 4'd2) begin n_fail++; $display("FAIL lp_digits: got %0d/%0d expected 5/2", code1, code2); end
    obs_q.delete();
    run_cycles(12);
    n_tests++; if (obs_q.size() != 0 || busy !== 1'b0 || digits() !== 52) begin n_fail++; $display("FAIL lp_hold: got %0d events busy %b digits %0d expected 0 events busy 0 digits 52", obs_q.size(), busy, digits()); end
  endtask

  task automatic test_pause_on_tick();
    ev_t e, o;
    do_load(8'd10); tick();
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    pause = 1'b1; tick(); pause = 1'b0;
    tick();
    n_tests++; if (digits() !== 10 || busy !== 1'b1) begin n_fail++; $display("FAIL pt_nodec: got %0d busy %b expected 10 busy 1", digits(), busy); end
    start = 1'b1; pause = 1'b1; tick(); start = 1'b0; pause = 1'b0;
    tick(); tick();
    n_tests++; if (digits() !== 10 || busy !== 1'b1) begin n_fail++; $display("FAIL pt_stay: got %0d busy %b expected 10 busy 1", digits(), busy); end
    start = 1'b1; tick(); start = 1'b0;
    exp_q.delete(); obs_q.delete();
    exp_q.push_back('{2, 0, 9});
    run_cycles(2);
    n_tests++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL pt_events: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
      if (o.cyc != e.cyc || o.kind != e.kind || o.val != e.val) begin
        n_fail++; $display("FAIL pt_ev: got cyc %0d kind %0d val %0d expected cyc %0d kind %0d val %0d", o.cyc, o.kind, o.val, e.cyc, e.kind, e.val);
      end
    end
  endtask

  task automatic test_reset_midrun();
    do_load(8'd20);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 25; i++) tick();
    n_tests++; if (digits() !== 14) begin n_fail++; $display("FAIL rm_pre: got %0d expected 14", digits()); end
    rst = 1'b1; tick(); rst = 1'b0;
    n_tests++; if ({code1, code2, busy, done, blank} !== 11'd0) begin n_fail++; $display("FAIL rm_outputs: got %b expected 0", {code1, code2, busy, done, blank}); end
    obs_q.delete();
    run_cycles(10);
    n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL rm_nodone: got %0d events expected 0", obs_q.size()); end
    start = 1'b1; tick(); start = 1'b0;
    n_tests++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rm_zero_start: got done %b busy %b expected 1 0", done, busy); end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_pause_resume();
    test_saturate_zero();
    test_load_priority();
    test_pause_on_tick();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/washer_countdown.md
# washer_countdown

Countdown sequencer for the washer front panel. It holds the remaining wash time (0–99 units) and decrements it once per prescaled tick while running. It supports load, start, pause and resume, and drives the tens and units BCD digits straight into the `shumaguan` display driver's `code1`/`code2` inputs. It also produces a blank/blink control and a one-cycle completion pulse for the wash-cycle FSM.

## Interface
Parameters:
- `TICK_DIV`, default 100: `qclock` cycles per countdown step (1 s at the 100 Hz panel clock). Legal range is 2 or more.
- `BLINK_DIV`, default 50: `qclock` cycles per `blank` toggle in PAUSE and DONE. Legal range is 1 or more.
- `MAX_VAL`, default 99: saturation limit for `load_val`. Must be 99 or less.

Ports:
- `qclock`  in  1: single clock. All logic is rising-edge.
- `rst`  in  1: synchronous, active-high reset.
- `load`  in  1: level-sampled. Captures `load_val` on any cycle it is high.
- `load_val`  in  8: binary preset value.
- `start`  in  1: starts from IDLE, or resumes from PAUSE.
- `pause`  in  1: freezes the countdown while in RUN.
- `code1`  out  4: tens digit, BCD, connects to `shumaguan.code1`.
- `code2`  out  4: units digit, BCD, connects to `shumaguan.code2`.
- `busy`  out  1: high in RUN and PAUSE.
- `done`  out  1: one-cycle pulse on completion.
- `blank`  out  1: when high, the display consumer blanks both digits.

## Operation
Internal registers:
- `cnt`: 7-bit remaining value, binary.
- `pre`: prescaler, 0 to TICK_DIV-1.
- `blk`: blink counter.
- `state`: one of IDLE, RUN, PAUSE, DONE.

Digit outputs:
- `code1` = `cnt` / 10 and `code2` = `cnt` % 10, registered so they update the cycle after `cnt` changes.
- Both digits are always valid BCD (0–9).

Load:
- Allowed in any state.
- Sets `cnt` = min(`load_val`, MAX_VAL), clears `pre` and `blk`, and sets state to IDLE.
- `load` has priority over `start` and `pause` in the same cycle; those are ignored.

State transitions:
- IDLE, `start`, `cnt` > 0: go to RUN with `pre` = 0.
- IDLE, `start`, `cnt` = 0: go to DONE immediately, and `done` pulses.
- RUN: `pre` increments each cycle. When `pre` = TICK_DIV-1, `pre` wraps to 0 and `cnt` decrements.
- RUN, tick where `cnt` goes 1→0: go to DONE.
- RUN, `pause`: go to PAUSE. `pre` and `cnt` hold.
- RUN, `pause` on a tick cycle: `pause` wins and no decrement occurs.
- PAUSE, `start`: go to RUN. `pre` continues from its held value.
- PAUSE, `start` and `pause` together: stay in PAUSE.
- DONE: hold until `load` or `rst`. `start` and `pause` are ignored. `cnt` stays 0.

`blank` behaviour:
- 0 in IDLE and RUN.
- In PAUSE and DONE, toggles every BLINK_DIV cycles. The first toggle (0→1) happens BLINK_DIV cycles after entering the state.
- Returns to 0 on the same edge the state leaves PAUSE or DONE.

`done`:
- Registered. High for exactly the one cycle after the edge that enters DONE.

## Timing
- Reset values: state = IDLE, `cnt` = 0, `pre` = 0, `blk` = 0, `code1` = 0, `code2` = 0, `busy` = 0, `done` = 0, `blank` = 0.
- Reset mid-run aborts with no `done` pulse.
- `start` sampled at edge E with `cnt` = N > 0 gives:
  - `busy` high from E+1;
  - first decrement at edge E + TICK_DIV;
  - `code1`/`code2` reflecting N−1 at E + TICK_DIV + 1;
  - DONE entered at E + N·TICK_DIV, with `done` high during the following cycle.
- Pause and resume is lossless: total RUN cycles from start to DONE is exactly N·TICK_DIV, regardless of pauses.
- Load during RUN or PAUSE: `busy` drops at the next edge and the digits show the new value one cycle later.
- `load_val` of 100–255 saturates to MAX_VAL; `code1`/`code2` = 9/9.
- Inputs are assumed synchronous to `qclock`. The block performs no debouncing.

## Test plan
Run with `TICK_DIV` = 4 and `BLINK_DIV` = 2.
- Reset, then load 13, then start → digits 1/3, 1/2, …, 0/0. Each step is 4 cycles apart. `done` is high for exactly one cycle at cycle 52 after start.
- Load 26, start, pause after 10 cycles for 20 cycles, then start → `cnt` = 24 during pause and `blank` toggles every 2 cycles. DONE arrives 104 RUN cycles after the first start.
- Load 200 → digits 9/9. Load 0 then start → DONE the next edge and `done` pulses once. `busy` never goes high.
- Same-cycle `load` 52 and `start` while in RUN → state becomes IDLE, digits 5/2, and no decrement follows.
- `pause` asserted on a tick cycle → no decrement that tick. `start` and `pause` together in PAUSE → stays paused.
- `rst` mid-RUN with `cnt` = 14 → all outputs 0 the next cycle, and no `done` pulse. After that, `start` with `cnt` = 0 goes straight to DONE.
